enc_r: RTL and testbench

R-type instruction encoder with an output queue: accepts decoded R-type operations (internal 8-bit instruction enum plus register/shift fields) and produces canonical 32-bit MIPS SPECIAL-opcode instruction words. It is the inverse of the R-type decode stage. It feeds the debug/instruction-injection path that supplies generated code words to fetch. Requests are encoded, buffered in a small FIFO and drained through a valid/ready handshake. Unencodable requests are dropped and counted.

---
 rtl/enc_r_pkg.sv | 64 ++++++
 rtl/enc_r_fifo_sync.sv | 75 +++++++
 rtl/enc_r.sv | 158 +++++++++++++++
 tb/tb_enc_r.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/enc_r_pkg.sv
// rtl/enc_r_pkg.sv - shared R-type instruction enum, SPECIAL funct codes and encode result type
package enc_r_pkg;

    typedef enum logic [7:0] {
        INST_INVALID = 8'd0,
        INST_SLL     = 8'd1,
        INST_SRL     = 8'd2,
        INST_SRA     = 8'd3,
        INST_SLLV    = 8'd4,
        INST_SRLV    = 8'd5,
        INST_SRAV    = 8'd6,
        INST_JR      = 8'd7,
        INST_JALR    = 8'd8,
        INST_SYSCALL = 8'd9,
        INST_BREAK   = 8'd10,
        INST_MFHI    = 8'd11,
        INST_MTHI    = 8'd12,
        INST_MFLO    = 8'd13,
        INST_MTLO    = 8'd14,
        INST_MULT    = 8'd15,
        INST_DIVU    = 8'd16,
        INST_ADDU    = 8'd17,
        INST_SUBU    = 8'd18,
        INST_AND     = 8'd19,
        INST_OR      = 8'd20,
        INST_XOR     = 8'd21,
        INST_NOR     = 8'd22,
        INST_SLT     = 8'd23,
        INST_SLTU    = 8'd24
    } inst_e;

    localparam logic [5:0] OPC_SPECIAL   = 6'h00;

    localparam logic [5:0] FUNCT_SLL     = 6'h00;
    localparam logic [5:0] FUNCT_SRL     = 6'h02;
    localparam logic [5:0] FUNCT_SRA     = 6'h03;
    localparam logic [5:0] FUNCT_SLLV    = 6'h04;
    localparam logic [5:0] FUNCT_SRLV    = 6'h06;
    localparam logic [5:0] FUNCT_SRAV    = 6'h07;
    localparam logic [5:0] FUNCT_JR      = 6'h08;
    localparam logic [5:0] FUNCT_JALR    = 6'h09;
    localparam logic [5:0] FUNCT_SYSCALL = 6'h0c;
    localparam logic [5:0] FUNCT_BREAK   = 6'h0d;
    localparam logic [5:0] FUNCT_MFHI    = 6'h10;
    localparam logic [5:0] FUNCT_MTHI    = 6'h11;
    localparam logic [5:0] FUNCT_MFLO    = 6'h12;
    localparam logic [5:0] FUNCT_MTLO    = 6'h13;
    localparam logic [5:0] FUNCT_MULT    = 6'h18;
    localparam logic [5:0] FUNCT_DIVU    = 6'h1b;
    localparam logic [5:0] FUNCT_ADDU    = 6'h21;
    localparam logic [5:0] FUNCT_SUBU    = 6'h23;
    localparam logic [5:0] FUNCT_AND     = 6'h24;
    localparam logic [5:0] FUNCT_OR      = 6'h25;
    localparam logic [5:0] FUNCT_XOR     = 6'h26;
    localparam logic [5:0] FUNCT_NOR     = 6'h27;
    localparam logic [5:0] FUNCT_SLT     = 6'h2a;
    localparam logic [5:0] FUNCT_SLTU    = 6'h2b;

    typedef struct packed {
        logic        ok;
        logic [31:0] word;
    } enc_res_t;

endpackage

// File: rtl/enc_r_fifo_sync.sv
// rtl/enc_r_fifo_sync.sv - synchronous FIFO with flush, power-of-two depth
module fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Flush wins over both push and pop on the same edge.
    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/enc_r.sv
// rtl/enc_r.sv - R-type MIPS SPECIAL encoder with output FIFO and drop counter
module enc_r
    import enc_r_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_inst,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_shift,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_code,
    output logic        err,
    output logic [7:0]  drop_cnt
);

    function automatic enc_res_t encode(
        input logic [7:0] inst,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sh
    );
        enc_res_t   r;
        logic [4:0] f_rs, f_rt, f_rd, f_sh;
        logic [5:0] fn;
        r.ok = 1'b1;
        f_rs = rs;
        f_rt = rt;
        f_rd = rd;
        f_sh = sh;
        fn   = 6'h00;
        case (inst)
            INST_SLL:     fn = FUNCT_SLL;
            INST_SRL:     fn = FUNCT_SRL;
            INST_SRA:     fn = FUNCT_SRA;
            INST_SLLV:    fn = FUNCT_SLLV;
            INST_SRLV:    fn = FUNCT_SRLV;
            INST_SRAV:    fn = FUNCT_SRAV;
            INST_JR:      fn = FUNCT_JR;
            INST_JALR:    fn = FUNCT_JALR;
            INST_SYSCALL: fn = FUNCT_SYSCALL;
            INST_BREAK:   fn = FUNCT_BREAK;
            INST_MFHI:    fn = FUNCT_MFHI;
            INST_MTHI:    fn = FUNCT_MTHI;
            INST_MFLO:    fn = FUNCT_MFLO;
            INST_MTLO:    fn = FUNCT_MTLO;
            INST_MULT:    fn = FUNCT_MULT;
            INST_DIVU:    fn = FUNCT_DIVU;
            INST_ADDU:    fn = FUNCT_ADDU;
            INST_SUBU:    fn = FUNCT_SUBU;
            INST_AND:     fn = FUNCT_AND;
            INST_OR:      fn = FUNCT_OR;
            INST_XOR:     fn = FUNCT_XOR;
            INST_NOR:     fn = FUNCT_NOR;
            INST_SLT:     fn = FUNCT_SLT;
            INST_SLTU:    fn = FUNCT_SLTU;
            default:      r.ok = 1'b0;
        endcase
        // Canonical form: fields the instruction does not use are forced to zero.
        case (inst)
            INST_SLL, INST_SRL, INST_SRA: f_rs = '0;
            INST_SLLV, INST_SRLV, INST_SRAV,
            INST_ADDU, INST_SUBU, INST_AND, INST_OR, INST_XOR, INST_NOR,
            INST_SLT, INST_SLTU: f_sh = '0;
            INST_JR, INST_MTHI, INST_MTLO: begin
                f_rt = '0;
                f_rd = '0;
                f_sh = '0;
            end
            INST_JALR: begin
                f_rt = '0;
                f_sh = '0;
            end
            INST_SYSCALL, INST_BREAK: begin
                f_rs = '0;
                f_rt = '0;
                f_rd = '0;
                f_sh = '0;
            end
            INST_MFHI, INST_MFLO: begin
                f_rs = '0;
                f_rt = '0;
                f_sh = '0;
            end
            INST_MULT, INST_DIVU: begin
                f_rd = '0;
                f_sh = '0;
            end
            default: ;
        endcase
        r.word = r.ok ? {OPC_SPECIAL, f_rs, f_rt, f_rd, f_sh, fn} : 32'h0;
        return r;
    endfunction

    enc_res_t    enc;
    logic        full, empty;
    logic [31:0] head;
    logic        accept, push, pop, drop;
    logic        err_q, err_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    always_comb enc = encode(req_inst, req_rs, req_rt, req_rd, req_shift);

    assign req_ready = !full;
    assign out_valid = !empty;
    assign out_code  = empty ? 32'h0 : head;

    assign accept = req_valid && req_ready;
    assign push   = accept && enc.ok && !flush;
    assign pop    = out_valid && out_ready;
    // Unencodable requests are still handshaken so the injector never stalls on them.
    assign drop   = accept && !enc.ok;

    always_comb begin
        err_d      = drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hff)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err      = err_q;
    assign drop_cnt = drop_cnt_q;

    fifo_sync #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (enc.word),
        .full    (full),
        .empty   (empty),
        .rd_data (head)
    );

endmodule

// File: tb/tb_enc_r.sv
// tb/tb_enc_r.sv - directed self-checking bench for enc_r
module tb_enc_r;
    import enc_r_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_inst;
    logic [4:0]  req_rs, req_rt, req_rd, req_shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_code;
    logic        err;
    logic [7:0]  drop_cnt;

    int tests = 0;
    int fails = 0;

    enc_r #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_inst  (req_inst),
        .req_rs    (req_rs),
        .req_rt    (req_rt),
        .req_rd    (req_rd),
        .req_shift (req_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .err       (err),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input logic [7:0] inst, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh);
        req_valid = 1'b1;
        req_inst  = inst;
        req_rs    = rs;
        req_rt    = rt;
        req_rd    = rd;
        req_shift = sh;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        req_inst = 8'h00; req_rs = '0; req_rt = '0; req_rd = '0; req_shift = '0;
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_code", out_code, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_drop_cnt", {24'b0, drop_cnt}, 32'h0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        rst_n = 1'b1;
        tick();

        // Streaming with consumer always ready: each word visible exactly one cycle.
        out_ready = 1'b1;
        setreq(INST_ADDU, 5'd1, 5'd2, 5'd3, 5'd7);
        tick();
        chk("addu_valid", {31'b0, out_valid}, 32'h1);
        chk("addu_code", out_code, 32'h00221821);
        setreq(INST_SLL, 5'd9, 5'd1, 5'd2, 5'd4);
        tick();
        chk("sll_code", out_code, 32'h00011100);
        setreq(INST_JR, 5'd31, 5'd7, 5'd7, 5'd7);
        tick();
        chk("jr_code", out_code, 32'h03e00008);
        setreq(INST_SYSCALL, 5'd3, 5'd4, 5'd5, 5'd6);
        tick();
        chk("syscall_code", out_code, 32'h0000000c);
        setreq(INST_MFHI, 5'd1, 5'd2, 5'd5, 5'd3);
        tick();
        chk("mfhi_code", out_code, 32'h00002810);
        setreq(INST_MTLO, 5'd6, 5'd2, 5'd5, 5'd3);
        tick();
        chk("mtlo_code", out_code, 32'h00c00013);
        chk("stream_err", {31'b0, err}, 32'h0);
        req_valid = 1'b0;
        tick();
        chk("stream_drained", {31'b0, out_valid}, 32'h0);

        // Invalid requests are accepted, not queued, and counted.
        setreq(INST_INVALID, 5'd1, 5'd1, 5'd1, 5'd1);
        tick();
        req_valid = 1'b0;
        chk("inv_ready", {31'b0, req_ready}, 32'h1);
        chk("inv_no_valid", {31'b0, out_valid}, 32'h0);
        chk("inv_err", {31'b0, err}, 32'h1);
        chk("inv_cnt", {24'b0, drop_cnt}, 32'h1);
        tick();
        chk("inv_err_pulse", {31'b0, err}, 32'h0);
        setreq(8'hff, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
        req_valid = 1'b0;
        chk("inv_ff_cnt", {24'b0, drop_cnt}, 32'h2);

        // Fill to DEPTH, 5th request stalls, drain in order.
        out_ready = 1'b0;
        setreq(INST_ADDU, 5'd1, 5'd2, 5'd3, 5'd0);
        tick();
        setreq(INST_SUBU, 5'd4, 5'd5, 5'd6, 5'd9);
        tick();
        setreq(INST_SRA, 5'd3, 5'd7, 5'd8, 5'd31);
        tick();
        setreq(INST_JALR, 5'd31, 5'd5, 5'd31, 5'd3);
        tick();
        setreq(INST_MULT, 5'd2, 5'd3, 5'd4, 5'd5);
        chk("full_ready", {31'b0, req_ready}, 32'h0);
        tick();
        chk("full_stall", {31'b0, req_ready}, 32'h0);
        chk("full_head", out_code, 32'h00221821);
        out_ready = 1'b1;
        tick();
        chk("drain_w1", out_code, 32'h00853023);
        chk("drain_ready", {31'b0, req_ready}, 32'h1);
        tick();
        req_valid = 1'b0;
        chk("drain_w2", out_code, 32'h000747c3);
        tick();
        chk("drain_w3", out_code, 32'h03e0f809);
        tick();
        chk("drain_w4", out_code, 32'h00430018);
        tick();
        chk("drain_empty", {31'b0, out_valid}, 32'h0);

        // Flush with a full FIFO and a pending request.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setreq(INST_OR, 5'd1, 5'd1, 5'd1, 5'd0);
            tick();
        end
        setreq(INST_XOR, 5'd2, 5'd2, 5'd2, 5'd0);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'h0);
        chk("flush_ready", {31'b0, req_ready}, 32'h1);
        chk("flush_cnt", {24'b0, drop_cnt}, 32'h2);
        // Flush with a push into an empty FIFO discards the push.
        setreq(INST_AND, 5'd2, 5'd2, 5'd2, 5'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_push_valid", {31'b0, out_valid}, 32'h0);
        chk("flush_push_err", {31'b0, err}, 32'h0);
        out_ready = 1'b0;

        // 300 invalid requests: counter saturates.
        setreq(INST_INVALID, 5'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 300; i++) tick();
        req_valid = 1'b0;
        chk("sat_err", {31'b0, err}, 32'h1);
        chk("sat_cnt", {24'b0, drop_cnt}, 32'hff);
        tick();
        chk("sat_hold", {24'b0, drop_cnt}, 32'hff);
        chk("sat_err_low", {31'b0, err}, 32'h0);

        // Asynchronous reset mid-stream with 3 words queued.
        setreq(INST_NOR, 5'd1, 5'd2, 5'd3, 5'd0);
        tick(); tick(); tick();
        req_valid = 1'b0;
        chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_code", out_code, 32'h0);
        chk("arst_cnt", {24'b0, drop_cnt}, 32'h0);
        chk("arst_ready", {31'b0, req_ready}, 32'h1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", {31'b0, out_valid}, 32'h0);
        setreq(INST_ADDU, 5'd1, 5'd2, 5'd3, 5'd7);
        tick();
        req_valid = 1'b0;
        chk("post_rst_code", out_code, 32'h00221821);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
